// File: rtl/imem_boot_loader_pkg.sv
// Shared types and default widths for the instruction-memory boot loader.
// The CPU integration top also imports this to size its instruction memory.
package boot_pkg;
   localparam int ADDR_W_DEF   = 8;
   localparam int DATA_W_DEF   = 32;
   localparam int RST_HOLD_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      LOAD,
      HOLD,
      RUN,
      ERR
   } boot_state_e;
endpackage

// File: rtl/imem_boot_loader_if.sv
// Valid/ready word stream carrying the program image into the boot loader.
interface imem_boot_loader_if #(
   parameter int DATA_W = 32
) ();
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;

   modport master (output s_valid, output s_data, input  s_ready);
   modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory and holds
// the CPU in reset until the final word has been written.
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RST_HOLD = RST_HOLD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   imem_boot_loader_if.slave s,
   input  logic              reload,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);
   localparam int                DEPTH   = 2 ** ADDR_W;
   localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

   boot_state_e       state_reg, state_next;
   logic [ADDR_W:0]   cnt_reg, cnt_next;
   logic [ADDR_W:0]   len_reg, len_next;
   logic [7:0]        hold_reg, hold_next;
   logic              im_we_next, cpu_rst_next, done_next, err_next;
   logic [ADDR_W-1:0] im_addr_next;
   logic [DATA_W-1:0] im_wdata_next;
   logic              accept;

   assign s.s_ready = (state_reg == LEN) || (state_reg == LOAD);
   assign accept    = s.s_valid && s.s_ready;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      len_next      = len_reg;
      hold_next     = hold_reg;
      im_we_next    = 1'b0;
      im_addr_next  = im_addr;
      im_wdata_next = im_wdata;
      cpu_rst_next  = cpu_rst;
      done_next     = done;
      err_next      = err;

      // reload overrides whatever handshake happens on the same edge
      if (reload && state_reg != IDLE) begin
         state_next   = LEN;
         cpu_rst_next = 1'b1;
         done_next    = 1'b0;
         err_next     = 1'b0;
         cnt_next     = '0;
      end else begin
         unique case (state_reg)
            IDLE: state_next = LEN;
            LEN: if (accept) begin
               if (s.s_data == '0 || s.s_data > DEPTH_W) begin
                  err_next   = 1'b1;
                  state_next = ERR;
               end else begin
                  len_next   = s.s_data[ADDR_W:0];
                  cnt_next   = '0;
                  state_next = LOAD;
               end
            end
            LOAD: if (accept) begin
               im_we_next    = 1'b1;
               im_addr_next  = cnt_reg[ADDR_W-1:0];
               im_wdata_next = s.s_data;
               cnt_next      = cnt_reg + 1'b1;
               if (cnt_reg == len_reg - 1'b1) begin
                  hold_next  = 8'(RST_HOLD);
                  state_next = HOLD;
               end
            end
            HOLD: begin
               if (hold_reg == '0) begin
                  state_next   = RUN;
                  cpu_rst_next = 1'b0;
                  done_next    = 1'b1;
               end else begin
                  hold_next = hold_reg - 1'b1;
               end
            end
            RUN:     ;
            ERR:     ;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         len_reg   <= '0;
         hold_reg  <= '0;
         im_we     <= 1'b0;
         im_addr   <= '0;
         im_wdata  <= '0;
         cpu_rst   <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
         hold_reg  <= hold_next;
         im_we     <= im_we_next;
         im_addr   <= im_addr_next;
         im_wdata  <= im_wdata_next;
         cpu_rst   <= cpu_rst_next;
         done      <= done_next;
         err       <= err_next;
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: nominal load, gaps, bad lengths,
// full-depth image, reload mid-load and asynchronous reset.
module tb_imem_boot_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        reload = 1'b0;
   logic        im_we;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;
   logic        cpu_rst, done, err;

   int checks = 0;
   int errors = 0;
   int          wr_addr[$];
   logic [31:0] wr_data[$];

   imem_boot_loader_if #(.DATA_W(32)) sif ();

   imem_boot_loader #(.ADDR_W(8), .DATA_W(32), .RST_HOLD(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .s        (sif),
      .reload   (reload),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // write log: a pulse registered at one edge is seen at the next edge
   always @(posedge clk) begin
      if (im_we) begin
         wr_addr.push_back(int'(im_addr));
         wr_data.push_back(im_wdata);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] d, output int waits);
      waits = 0;
      sif.s_valid = 1'b1;
      sif.s_data  = d;
      while (!sif.s_ready && waits < 20) begin
         step();
         waits++;
      end
      checks++;
      if (!sif.s_ready) begin
         errors++;
         $display("FAIL send_word: s_ready=0 after %0d cycles, required 1 (data=%h)", waits, d);
      end else begin
         step();
         waits++;
         $display("accept data=%h after %0d edge(s)", d, waits);
      end
      sif.s_valid = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      step();
      reload = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL wait_done: done=%b, required 1", done);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({sif.s_ready, im_we, im_addr, im_wdata, cpu_rst, done, err} !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b we=%b addr=%h wdata=%h cpu_rst=%b done=%b err=%b, required 0 0 00 0 1 0 0",
                  sif.s_ready, im_we, im_addr, im_wdata, cpu_rst, done, err);
      end
      rst = 1'b1;
      step();
      checks++;
      if (sif.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: s_ready=%b, required 1", sif.s_ready);
      end
   endtask

   task automatic test_nominal();
      logic [31:0] img [3] = '{32'h20080005, 32'h20090007, 32'h01095020};
      int w;
      wr_addr.delete(); wr_data.delete();
      send_word(32'd3, w);
      for (int i = 0; i < 3; i++) send_word(img[i], w);
      step();
      checks++;
      if (cpu_rst !== 1'b1) begin errors++; $display("FAIL nominal_hold1: cpu_rst=%b, required 1", cpu_rst); end
      step();
      checks++;
      if (cpu_rst !== 1'b1) begin errors++; $display("FAIL nominal_hold2: cpu_rst=%b, required 1", cpu_rst); end
      step();
      checks++;
      if (cpu_rst !== 1'b0 || done !== 1'b1 || sif.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL nominal_release: cpu_rst=%b done=%b ready=%b, required 0 1 0", cpu_rst, done, sif.s_ready);
      end
      checks++;
      if (wr_addr.size() != 3) begin
         errors++;
         $display("FAIL nominal_write_count: %0d writes, required 3", wr_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] !== img[i]) begin
               errors++;
               $display("FAIL nominal_write%0d: addr=%0d data=%h, required %0d %h", i, wr_addr[i], wr_data[i], i, img[i]);
            end
         end
      end
   endtask

   task automatic test_gaps();
      logic [31:0] img [3] = '{32'h20080005, 32'h20090007, 32'h01095020};
      int w;
      pulse_reload();
      wr_addr.delete(); wr_data.delete();
      send_word(32'd3, w);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (wr_addr.size() != i) begin
            errors++;
            $display("FAIL gaps_count_before_word%0d: %0d writes, required %0d", i, wr_addr.size(), i);
         end
         send_word(img[i], w);
         checks++;
         if (w != 1) begin
            errors++;
            $display("FAIL gaps_first_cycle%0d: accepted after %0d edges, required 1", i, w);
         end
      end
      wait_done();
      checks++;
      if (wr_addr.size() != 3 || wr_addr[2] != 2 || wr_data[2] !== img[2] || wr_data[0] !== img[0]) begin
         errors++;
         $display("FAIL gaps_writes: count=%0d, required 3 in order", wr_addr.size());
      end
   endtask

   task automatic test_bad_length();
      logic [31:0] bad [2] = '{32'd0, 32'd257};
      int w;
      for (int k = 0; k < 2; k++) begin
         pulse_reload();
         wr_addr.delete(); wr_data.delete();
         send_word(bad[k], w);
         step(); step(); step();
         checks++;
         if (err !== 1'b1 || sif.s_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL bad_len_%0d: err=%b ready=%b cpu_rst=%b done=%b writes=%0d, required 1 0 1 0 0",
                     bad[k], err, sif.s_ready, cpu_rst, done, wr_addr.size());
         end
      end
      pulse_reload();
      checks++;
      if (err !== 1'b0 || sif.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL bad_len_reload: err=%b ready=%b, required 0 1", err, sif.s_ready);
      end
      send_word(32'd1, w);
      send_word(32'h00001234, w);
      wait_done();
      checks++;
      if (err !== 1'b0 || wr_addr.size() != 1 || wr_data[0] !== 32'h00001234) begin
         errors++;
         $display("FAIL bad_len_recover: err=%b writes=%0d, required 0 1", err, wr_addr.size());
      end
   endtask

   task automatic test_boundary();
      int w;
      pulse_reload();
      wr_addr.delete(); wr_data.delete();
      send_word(32'd256, w);
      for (int i = 0; i < 256; i++) send_word(32'hA000_0000 + 32'(i), w);
      wait_done();
      checks++;
      if (wr_addr.size() != 256) begin
         errors++;
         $display("FAIL boundary_count: %0d writes, required 256", wr_addr.size());
      end else begin
         for (int i = 0; i < 256; i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] !== 32'hA000_0000 + 32'(i)) begin
               errors++;
               $display("FAIL boundary_write%0d: addr=%0d data=%h, required %0d %h",
                        i, wr_addr[i], wr_data[i], i, 32'hA000_0000 + 32'(i));
            end
         end
      end
   endtask

   task automatic test_reload_mid_load();
      int w;
      pulse_reload();
      wr_addr.delete(); wr_data.delete();
      send_word(32'd5, w);
      send_word(32'h00000011, w);
      send_word(32'h00000022, w);
      sif.s_valid = 1'b1;
      sif.s_data  = 32'h00000033;
      pulse_reload();
      sif.s_valid = 1'b0;
      checks++;
      if (sif.s_ready !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || wr_addr.size() != 2) begin
         errors++;
         $display("FAIL reload_mid: ready=%b cpu_rst=%b done=%b writes=%0d, required 1 1 0 2",
                  sif.s_ready, cpu_rst, done, wr_addr.size());
      end
      step();
      checks++;
      if (wr_addr.size() != 2) begin
         errors++;
         $display("FAIL reload_mid_dropped: %0d writes, required 2", wr_addr.size());
      end
      send_word(32'd2, w);
      checks++;
      if (cpu_rst !== 1'b1 || sif.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reload_mid_new_len: cpu_rst=%b ready=%b, required 1 1", cpu_rst, sif.s_ready);
      end
      send_word(32'h00000044, w);
      send_word(32'h00000055, w);
      wait_done();
      checks++;
      if (wr_addr.size() != 4 || wr_addr[2] != 0 || wr_data[2] !== 32'h44 || wr_addr[3] != 1 || wr_data[3] !== 32'h55) begin
         errors++;
         $display("FAIL reload_mid_reload_image: writes=%0d, required 4 with 44@0 55@1", wr_addr.size());
      end
   endtask

   task automatic test_async_reset();
      int w;
      pulse_reload();
      send_word(32'd1, w);
      send_word(32'h00000066, w);
      step();
      #2 rst = 1'b0;
      #1;
      checks++;
      if (cpu_rst !== 1'b1 || done !== 1'b0 || sif.s_ready !== 1'b0 || im_we !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: cpu_rst=%b done=%b ready=%b we=%b, required 1 0 0 0", cpu_rst, done, sif.s_ready, im_we);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (sif.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_release_idle: s_ready=%b, required 0", sif.s_ready);
      end
      step();
      checks++;
      if (sif.s_ready !== 1'b1 || cpu_rst !== 1'b1) begin
         errors++;
         $display("FAIL async_release_len: ready=%b cpu_rst=%b, required 1 1", sif.s_ready, cpu_rst);
      end
   endtask

   initial begin
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      test_reset();
      test_nominal();
      test_gaps();
      test_bad_length();
      test_boundary();
      test_reload_mid_load();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the MIPS CPU. Receives a program image over a valid/ready word stream and writes it into instruction memory through its write port.
- Holds the CPU in reset while loading and releases it only after the last word has been written.
- Replaces the bench-side "hold rst, then drop it" sequencing with hardware, so the same image path works in simulation and on a board.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, instruction word width.
- RST_HOLD, 2, cycles cpu_rst stays high after the last accepted word; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset for this block.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  stream word: first word is the length N, then N instruction words.
- s_ready  out  1  loader can accept a word.
- reload  in  1  single-cycle pulse: abort or restart and begin a new image.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  ADDR_W  instruction-memory word address.
- im_wdata  out  DATA_W  instruction-memory write data.
- cpu_rst  out  1  active-high reset to the CPU.
- done  out  1  image loaded and CPU running.
- err  out  1  bad length received.

Behaviour:
- Async reset (rst=0), every register cleared immediately:
  - state=IDLE, s_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - cpu_rst=1, done=0, err=0, word count=0, hold counter=0.
- Handshake: a word is accepted at a rising edge where s_valid & s_ready. s_data must be stable while s_valid=1 and s_ready=0. s_ready is a decode of the registered state: 1 only in LEN and LOAD.
- States:
  - IDLE -> LEN after one clock, unconditionally.
  - LEN, on accept:
    - If N==0 or N>DEPTH: err<=1, go to ERR.
    - Otherwise latch N, cnt<=0, go to LOAD.
  - LOAD, on accept:
    - Next cycle: im_we=1, im_addr=cnt[ADDR_W-1:0], im_wdata=s_data.
    - cnt<=cnt+1.
    - If this was word N-1: hold<=RST_HOLD, go to HOLD.
    - im_we is a registered one-cycle pulse per accepted word, so back-to-back accepts give consecutive writes.
  - HOLD: hold decrements by 1 each cycle. In the cycle where hold==0, go to RUN, cpu_rst<=0, done<=1. cpu_rst therefore falls exactly RST_HOLD+1 edges after the edge that accepted the last word, and always after the last im_we.
  - RUN: cpu_rst=0, done=1, s_ready=0. Remains until reload.
  - ERR: cpu_rst=1, s_ready=0, err=1. Remains until reload.
- reload pulse, in any state except IDLE:
  - Next state LEN; cpu_rst<=1, done<=0, err<=0, cnt<=0.
  - Any in-flight im_we from the same edge still completes.
  - A word presented with s_valid on the reload edge is not accepted.
  - reload takes priority over a handshake on the same edge.
- Width rules:
  - N is compared as a full DATA_W unsigned value against DEPTH.
  - cnt is ADDR_W+1 bits so that N==DEPTH is legal.
  - im_addr never wraps within one image.
- Async reset asserted mid-load returns to IDLE immediately. Memory contents are left as written.

Decomposition:
- Shared package boot_pkg:
  - State enum: IDLE, LEN, LOAD, HOLD, RUN, ERR.
  - Default widths: ADDR_W, DATA_W.
  - RST_HOLD default.
- No sub-module. The hold down-counter stays inline.
- The integration top instantiates imem_boot_loader beside CPU and ties cpu_rst to the CPU's rst.

Test Plan:
- Nominal load: stream 3, 0x20080005, 0x20090007, 0x01095020 with s_valid held high -> three im_we pulses at addresses 0, 1, 2 with matching data; cpu_rst falls 3 edges after the last accept; done=1.
- Backpressure and gaps: same image with s_valid toggled 1,0,1,0 -> writes only on accept edges, order and addresses unchanged; the word after each gap is accepted on its first valid cycle.
- Bad length:
  - N=0 -> err=1, s_ready=0, cpu_rst stays 1, no im_we.
  - N=257 with ADDR_W=8 -> same response.
  - A following reload and valid image -> err clears and the load succeeds.
- Boundary length: N=256 with ADDR_W=8 -> last write at im_addr=0xFF, no wrap; done=1.
- Reload mid-load: reload pulse after 2 of 5 words with s_valid=1 on that edge -> that word is not written; state returns to LEN; the next word is treated as length; cpu_rst stays 1.
- Async reset mid-HOLD: drive rst=0 between clock edges -> cpu_rst=1 and done=0 with no clock edge; after rst=1, s_ready rises one cycle later.
